// File: rtl/race_pkg.sv
// Shared constants for the race sequencer: animal codes, idle mode code and FSM state encoding.
package race_pkg;

    localparam logic [1:0] CAT   = 2'b00;
    localparam logic [1:0] DOG   = 2'b01;
    localparam logic [1:0] MOUSE = 2'b10;

    localparam logic [3:0] MODE_IDLE = 4'b1111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_HOME = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

    // Round-robin order cat -> dog -> mouse -> cat.
    function automatic logic [1:0] next_animal(input logic [1:0] a);
        return (a == MOUSE) ? CAT : a + 2'd1;
    endfunction

endpackage

// File: rtl/race_sequencer_if.sv
// Control/status bundle between the race sequencer and its host (buttons in, dot-matrix code out).
interface race_sequencer_if;

    logic       start;
    logic       abort;
    logic [3:0] mode;
    logic [1:0] winner;
    logic       done;
    logic       busy;

    modport master (
        output start,
        output abort,
        input  mode,
        input  winner,
        input  done,
        input  busy
    );

    modport slave (
        input  start,
        input  abort,
        output mode,
        output winner,
        output done,
        output busy
    );

endinterface

// File: rtl/race_lfsr.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1; reseeded only by reset.
module race_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk1khz,
    input  logic       rst_n,
    input  logic       enable,
    output logic [7:0] state
);

    logic [7:0] r_state;
    logic       w_fb;

    assign w_fb = r_state[7] ^ r_state[5] ^ r_state[4] ^ r_state[3];

    always_ff @(posedge clk1khz) begin
        if (!rst_n) begin
            r_state <= SEED;
        end else if (enable) begin
            r_state <= {r_state[6:0], w_fb};
        end
    end

    assign state = r_state;

endmodule

// File: rtl/race_sequencer.sv
// Animal race sequencer: paces a HOME intro and a random RUN at the step tick and
// presents a stable {animal, frame} code to the dot-matrix driver.
module race_sequencer #(
    parameter int         TICK_DIV  = 1000,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic              clk1khz,
    input  logic              rst_n,
    race_sequencer_if.slave   bus
);

    import race_pkg::*;

    localparam int             CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    state_t        r_state;
    logic [3:0]    r_mode;
    logic [1:0]    r_winner;
    logic [1:0]    r_frame_cat;
    logic [1:0]    r_frame_dog;
    logic [1:0]    r_frame_mouse;
    logic [1:0]    r_rr;
    logic [1:0]    r_home;

    logic          w_tick;
    logic          w_start_ok;
    logic          w_lfsr_en;
    logic [7:0]    w_lfsr;
    logic          w_lfsr_unused;
    logic [1:0]    w_cur;
    logic [1:0]    w_nf;

    assign w_tick     = (r_cnt == TC);
    assign w_start_ok = bus.start && !bus.abort &&
                        ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_lfsr_en  = w_tick && !bus.abort &&
                        ((r_state == ST_HOME) || (r_state == ST_RUN));

    race_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk1khz (clk1khz),
        .rst_n   (rst_n),
        .enable  (w_lfsr_en),
        .state   (w_lfsr)
    );

    // Only bit 0 steers the race; the rest is the generator's internal history.
    assign w_lfsr_unused = ^w_lfsr[7:1];

    always_comb begin
        w_cur = 2'b00;
        case (r_rr)
            CAT:     w_cur = r_frame_cat;
            DOG:     w_cur = r_frame_dog;
            MOUSE:   w_cur = r_frame_mouse;
            default: w_cur = 2'b00;
        endcase
        w_nf = (w_lfsr[0] && (w_cur != 2'b11)) ? w_cur + 2'd1 : w_cur;
    end

    always_ff @(posedge clk1khz) begin
        if (!rst_n) begin
            r_cnt         <= '0;
            r_state       <= ST_IDLE;
            r_mode        <= MODE_IDLE;
            r_winner      <= CAT;
            r_frame_cat   <= 2'b00;
            r_frame_dog   <= 2'b00;
            r_frame_mouse <= 2'b00;
            r_rr          <= CAT;
            r_home        <= CAT;
        end else begin
            if (w_start_ok || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (bus.abort) begin
                r_state       <= ST_IDLE;
                r_mode        <= MODE_IDLE;
                r_frame_cat   <= 2'b00;
                r_frame_dog   <= 2'b00;
                r_frame_mouse <= 2'b00;
                r_rr          <= CAT;
                r_home        <= CAT;
            end else begin
                case (r_state)
                    ST_IDLE, ST_DONE: begin
                        if (bus.start) begin
                            r_state       <= ST_HOME;
                            r_frame_cat   <= 2'b00;
                            r_frame_dog   <= 2'b00;
                            r_frame_mouse <= 2'b00;
                            r_rr          <= CAT;
                            r_home        <= CAT;
                        end
                    end
                    ST_HOME: begin
                        if (w_tick) begin
                            r_mode <= {r_home, 2'b00};
                            if (r_home == MOUSE) begin
                                r_state <= ST_RUN;
                            end else begin
                                r_home <= next_animal(r_home);
                            end
                        end
                    end
                    ST_RUN: begin
                        if (w_tick) begin
                            r_mode <= {r_rr, w_nf};
                            case (r_rr)
                                CAT:     r_frame_cat   <= w_nf;
                                DOG:     r_frame_dog   <= w_nf;
                                default: r_frame_mouse <= w_nf;
                            endcase
                            // First animal to reach frame 3 wins; its code stays on display.
                            if (w_nf == 2'b11) begin
                                r_winner <= r_rr;
                                r_state  <= ST_DONE;
                            end else begin
                                r_rr <= next_animal(r_rr);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.mode   = r_mode;
    assign bus.winner = r_winner;
    assign bus.done   = (r_state == ST_DONE);
    assign bus.busy   = (r_state == ST_HOME) || (r_state == ST_RUN);

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer at TICK_DIV=4 with two seeds (A5 and 01).
module tb_race_sequencer;

    logic clk1khz = 1'b0;
    logic rst_n   = 1'b0;

    always #5 clk1khz = ~clk1khz;

    race_sequencer_if ifa ();
    race_sequencer_if ifb ();

    race_sequencer #(.TICK_DIV(4), .LFSR_SEED(8'hA5)) dut_a (
        .clk1khz (clk1khz),
        .rst_n   (rst_n),
        .bus     (ifa)
    );

    race_sequencer #(.TICK_DIV(4), .LFSR_SEED(8'h01)) dut_b (
        .clk1khz (clk1khz),
        .rst_n   (rst_n),
        .bus     (ifb)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] m_lfsr   [2];
    logic [3:0] m_mode   [2];
    logic [1:0] m_winner [2];
    logic [1:0] first_winner;
    int         first_ticks;
    int         last_ticks;

    task automatic step();
        @(posedge clk1khz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_nx(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [3:0] o_mode(input int d);
        return (d == 0) ? ifa.mode : ifb.mode;
    endfunction
    function automatic logic o_done(input int d);
        return (d == 0) ? ifa.done : ifb.done;
    endfunction
    function automatic logic o_busy(input int d);
        return (d == 0) ? ifa.busy : ifb.busy;
    endfunction
    function automatic logic [1:0] o_winner(input int d);
        return (d == 0) ? ifa.winner : ifb.winner;
    endfunction

    task automatic set_start(input int d, input logic v);
        if (d == 0) ifa.start = v; else ifb.start = v;
    endtask
    task automatic set_abort(input int d, input logic v);
        if (d == 0) ifa.abort = v; else ifb.abort = v;
    endtask

    // Starts a race on DUT d and follows it tick by tick; stops after run_limit RUN ticks if nonzero.
    task automatic run_race(input int d, input int run_limit, input bit inj_start);
        logic [1:0] fr [4];
        logic [1:0] rr;
        logic [1:0] nf;
        int         t;
        set_start(d, 1'b1);
        step();
        set_start(d, 1'b0);
        chk("busy_after_start", o_busy(d), 1'b1);
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk("home_hold", o_mode(d), m_mode[d]);
                step();
            end
            m_mode[d] = {k[1:0], 2'b00};
            m_lfsr[d] = lfsr_nx(m_lfsr[d]);
            chk("home_mode", o_mode(d), m_mode[d]);
        end
        fr = '{default: 2'b00};
        rr = 2'b00;
        t  = 0;
        while (1) begin
            for (int j = 0; j < 4; j++) begin
                chk("run_hold", o_mode(d), m_mode[d]);
                chk("run_busy", o_busy(d), 1'b1);
                if (inj_start && t == 1 && j == 1) set_start(d, 1'b1);
                step();
                set_start(d, 1'b0);
            end
            nf = (m_lfsr[d][0] && fr[rr] != 2'b11) ? fr[rr] + 2'd1 : fr[rr];
            m_lfsr[d] = lfsr_nx(m_lfsr[d]);
            fr[rr]    = nf;
            m_mode[d] = {rr, nf};
            t++;
            chk("run_mode", o_mode(d), m_mode[d]);
            if (nf == 2'b11) begin
                m_winner[d] = rr;
                chk("done_at_tick", o_done(d), 1'b1);
                chk("winner", o_winner(d), m_winner[d]);
                chk("busy_in_done", o_busy(d), 1'b0);
                last_ticks = t;
                break;
            end
            chk("not_done_yet", o_done(d), 1'b0);
            rr = (rr == 2'b10) ? 2'b00 : rr + 2'd1;
            if (run_limit != 0 && t == run_limit) break;
            if (t >= 100) begin
                n_cmp++;
                n_err++;
                $error("FAIL race_timeout observed=%0d ticks expected=done", t);
                break;
            end
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        chk({tag, "_mode"}, o_mode(d), 4'b1111);
        chk({tag, "_done"}, o_done(d), 1'b0);
        chk({tag, "_busy"}, o_busy(d), 1'b0);
    endtask

    initial begin
        ifa.start = 1'b0; ifa.abort = 1'b0;
        ifb.start = 1'b0; ifb.abort = 1'b0;
        m_lfsr[0] = 8'hA5; m_lfsr[1] = 8'h01;
        m_mode[0] = 4'b1111; m_mode[1] = 4'b1111;
        m_winner[0] = 2'b00; m_winner[1] = 2'b00;
        last_ticks = 0;

        rst_n = 1'b0;
        repeat (3) step();
        check_idle(0, "rst_a");
        check_idle(1, "rst_b");
        chk("rst_a_winner", ifa.winner, 2'b00);
        chk("rst_b_winner", ifb.winner, 2'b00);
        rst_n = 1'b1;
        step();
        check_idle(0, "idle_a");

        // Full race, seed A5.
        run_race(0, 0, 1'b0);
        first_winner = m_winner[0];
        first_ticks  = last_ticks;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("done_hold_mode", ifa.mode, m_mode[0]);
            chk("done_hold_done", ifa.done, 1'b1);
            chk("done_hold_winner", ifa.winner, m_winner[0]);
        end

        // New race from DONE, aborted two ticks into RUN.
        run_race(0, 2, 1'b0);
        set_abort(0, 1'b1);
        step();
        set_abort(0, 1'b0);
        m_mode[0] = 4'b1111;
        check_idle(0, "abort");

        // start and abort together in IDLE: abort wins.
        set_start(0, 1'b1);
        set_abort(0, 1'b1);
        step();
        set_start(0, 1'b0);
        set_abort(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check_idle(0, "start_abort");
            step();
        end

        // Replay from IDLE after abort; LFSR continues where it left off.
        run_race(0, 0, 1'b0);

        // Seed 01 race with a stray start during RUN.
        run_race(1, 0, 1'b1);

        // Reset in the middle of a RUN.
        run_race(0, 2, 1'b0);
        rst_n = 1'b0;
        step();
        check_idle(0, "midrst_a");
        chk("midrst_a_winner", ifa.winner, 2'b00);
        check_idle(1, "midrst_b");
        chk("midrst_b_winner", ifb.winner, 2'b00);
        rst_n = 1'b1;
        m_lfsr[0] = 8'hA5; m_lfsr[1] = 8'h01;
        m_mode[0] = 4'b1111; m_mode[1] = 4'b1111;
        step();

        run_race(0, 0, 1'b0);
        chk("replay_winner", ifa.winner, first_winner);
        chk("replay_ticks", 8'(last_ticks), 8'(first_ticks));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/race_sequencer.md
RACE_SEQUENCER -- requirements
Module: race_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000, meaning clk1khz cycles per animation step (1 Hz at 1 kHz).
REQ-002 SHALL have parameter LFSR_SEED, default 8'hA5, meaning nonzero reset value of the race LFSR.
REQ-003 SHALL have port clk1khz  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse (debounced upstream) requesting a race.
REQ-006 SHALL have port abort  input  1  one-cycle pulse cancelling any activity.
REQ-007 SHALL have port mode  output  4  registered {animal[1:0], frame[1:0]} code for the dot-matrix driver: animal 00 cat, 01 dog, 10 mouse; frame 00..11.
REQ-008 SHALL have port winner  output  2  animal code of the race winner, valid while done=1.
REQ-009 SHALL have port done  output  1  high while in DONE.
REQ-010 SHALL have port busy  output  1  high while in HOME or RUN.

Function
REQ-011 SHALL generate an internal step tick: a modulo-TICK_DIV counter, tick is high for one cycle when the count equals TICK_DIV-1; counter clears on accepted start.
REQ-012 SHALL hold mode constant between ticks (TICK_DIV cycles), so any consumer sampling on its own 1 Hz edge sees a stable code.
REQ-013 SHALL implement FSM IDLE, HOME, RUN, DONE; mode updates only on tick, except on abort or reset.
REQ-014 IDLE: mode=4'b1111 (no-op code); start -> HOME; frames and round-robin index cleared.
REQ-015 HOME: on three successive ticks emit 4'b0000, 4'b0100, 4'b1000; after the third -> RUN.
REQ-016 RUN: on each tick, the current animal rr (order cat, dog, mouse, wrap 10->00) advances its frame by 1 if lfsr[0]=1, else keeps it; mode={rr, new frame}; rr increments.
REQ-017 RUN: when a new frame equals 2'b11, winner<=rr, enter DONE on the same edge; mode keeps that code.
REQ-018 DONE: done=1, mode and winner held; start -> HOME (new race, frames cleared).
REQ-019 LFSR SHALL be 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting once per tick in HOME and RUN, never reseeded except by reset.
REQ-020 start SHALL be ignored in HOME and RUN.
REQ-021 abort SHALL, in any state, force IDLE, mode=4'b1111, done=0, busy=0 on the next edge; LFSR not reseeded.
REQ-022 start and abort in the same cycle: abort wins.
REQ-023 Frame counters SHALL saturate at 2'b11 (never wrap to 00 during a race).

Reset
REQ-024 With rst_n=0 at a rising edge: state IDLE, mode=4'b1111, winner=2'b00, done=0, busy=0, frames=0, rr=0, tick counter=0, lfsr=LFSR_SEED.
REQ-025 Reset SHALL take precedence over start and abort, including mid-race.

Structure
REQ-026 Package race_pkg SHALL hold animal codes CAT=2'b00, DOG=2'b01, MOUSE=2'b10, MODE_IDLE=4'b1111, and the FSM state type.
REQ-027 The LFSR SHALL be sub-module race_lfsr (clk1khz, rst_n, enable, seed parameter, 8-bit state out).
REQ-028 Tick counter width SHALL be $clog2(TICK_DIV), minimum 1.

Verification (TICK_DIV=4)
REQ-029 rst_n low 3 cycles -> mode=1111, done=0, busy=0, winner=00.
REQ-030 start in IDLE -> busy=1; mode 0000, 0100, 1000 on ticks 1-3, each held exactly 4 cycles.
REQ-031 Seeds 8'hA5 and 8'h01 run to completion -> mode sequence, winner and tick of done match a cycle-accurate model; frames step only +0/+1 per own turn.
REQ-032 abort two ticks into RUN -> next cycle mode=1111, busy=0; later start replays HOME 0000/0100/1000.
REQ-033 start and abort same cycle in IDLE -> stays IDLE, busy=0; start during RUN -> no effect on mode sequence.
REQ-034 rst_n low mid-RUN -> all REQ-024 values after one edge; next race reproduces seed-8'hA5 sequence.
